// File: rtl/mem_arbiter.sv
// Arbitrates a shared single-port memory between an instruction-fetch port and a
// data port, with bounded data priority (starvation guard) and an access timeout.
module mem_arbiter #(
   parameter int unsigned TIMEOUT      = 15,
   parameter int unsigned STARVE_LIMIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        dm_read,
   input  logic        dm_write,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic        bus_err
);

   localparam int unsigned WAIT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GNT_DATA  = 2'd1,
      GNT_FETCH = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         dm_rdata_q, dm_rdata_d;
   logic                bus_err_q, bus_err_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [STARVE_W-1:0] starve_q, starve_d;

   logic data_pend, arb_ok, gnt_data, gnt_fetch, in_gnt, wait_hit, done, abort;

   // An ack cycle is a turnaround: no grant while a completion is being presented,
   // so the acked master can drop or renew its request before the next arbitration.
   assign data_pend = dm_read | dm_write;
   assign arb_ok    = (state_q == IDLE) & ~if_ack_q & ~dm_ack_q;
   assign gnt_data  = arb_ok & data_pend & (starve_q < STARVE_W'(STARVE_LIMIT));
   assign gnt_fetch = arb_ok & if_req & ~gnt_data;
   assign in_gnt    = (state_q != IDLE);
   assign wait_hit  = (wait_q == WAIT_W'(TIMEOUT));
   assign done      = in_gnt & (mem_ready | wait_hit);
   assign abort     = in_gnt & ~mem_ready & wait_hit;

   assign stall = (if_req & ~if_ack_q) | (data_pend & ~dm_ack_q);

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt_data)       state_d = GNT_DATA;
            else if (gnt_fetch) state_d = GNT_FETCH;
         end
         GNT_DATA, GNT_FETCH: begin
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture on grant, complete or abort on mem_ready/timeout, count waits and data streaks
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      bus_err_d   = 1'b0;
      wait_d      = wait_q;
      starve_d    = starve_q;
      if (gnt_data) begin
         mem_req_d   = 1'b1;
         mem_we_d    = dm_write;
         mem_addr_d  = dm_addr;
         mem_wdata_d = dm_wdata;
         wait_d      = '0;
      end else if (gnt_fetch) begin
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b0;
         mem_addr_d  = if_addr;
         mem_wdata_d = '0;
         wait_d      = '0;
      end else if (done) begin
         mem_req_d = 1'b0;
         mem_we_d  = 1'b0;
         bus_err_d = abort;
         if (state_q == GNT_DATA) begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = (abort | mem_we_q) ? '0 : mem_rdata;
         end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = abort ? '0 : mem_rdata;
         end
      end else if (in_gnt) begin
         wait_d = wait_q + WAIT_W'(1);
      end
      if (gnt_fetch | ~if_req) starve_d = '0;
      else if (gnt_data)       starve_d = starve_q + STARVE_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         bus_err_q   <= 1'b0;
         wait_q      <= '0;
         starve_q    <= '0;
      end else begin
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         bus_err_q   <= bus_err_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_ack    = if_ack_q;
   assign dm_ack    = dm_ack_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected accesses and acks,
// a memory responder and an ack monitor pop and compare as the DUT presents them.
module tb_mem_arbiter;

   localparam int unsigned TIMEOUT      = 15;
   localparam int unsigned STARVE_LIMIT = 2;
   localparam int          NEVER        = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_read = 1'b0;
   logic        dm_write = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall;
   logic        bus_err;

   mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
   } acc_t;

   typedef struct {
      bit          is_data;
      logic [31:0] rdata;
      bit          err;
   } ack_t;

   acc_t        exp_acc[$];
   ack_t        exp_ack[$];
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Background content of never-written words
   function automatic logic [31:0] fill(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : fill(a);
   endfunction

   // Memory responder: checks each new access against the expected order, then
   // answers after the access's planned number of wait cycles (or never).
   bit          in_acc = 1'b0;
   int          cnt = 0;
   acc_t        cur;
   logic [31:0] a0, w0;
   logic        we0;
   always @(negedge clk) begin
      if (mem_req) begin
         if (!in_acc) begin
            in_acc = 1'b1;
            cnt    = 0;
            a0     = mem_addr;
            w0     = mem_wdata;
            we0    = mem_we;
            if (exp_acc.size() == 0) begin
               check("unexpected_access", 32'(mem_req), 32'h0);
               cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, lat: NEVER};
            end else begin
               cur = exp_acc.pop_front();
               check("acc_we", 32'(mem_we), 32'(cur.we));
               check("acc_addr", mem_addr, cur.addr);
               if (cur.we) check("acc_wdata", mem_wdata, cur.wdata);
            end
         end else begin
            check("acc_hold_addr", mem_addr, a0);
            check("acc_hold_we", 32'(mem_we), 32'(we0));
            check("acc_hold_wdata", mem_wdata, w0);
         end
         if (cnt == cur.lat) begin
            mem_ready = 1'b1;
            if (cur.we) begin
               mem_arr[mem_addr] = mem_wdata;
               mem_rdata = $urandom;
            end else begin
               mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : fill(mem_addr);
            end
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         cnt++;
      end else begin
         in_acc    = 1'b0;
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
   end

   // Ack monitor
   always @(negedge clk) begin : ack_mon
      ack_t e;
      if (if_ack || dm_ack) begin
         if (exp_ack.size() == 0) begin
            check("unexpected_ack", {30'h0, if_ack, dm_ack}, 32'h0);
         end else begin
            e = exp_ack.pop_front();
            check("ack_src", 32'(dm_ack), 32'(e.is_data));
            check("ack_both", 32'(if_ack & dm_ack), 32'h0);
            check("ack_rdata", e.is_data ? dm_rdata : if_rdata, e.rdata);
            check("ack_bus_err", 32'(bus_err), 32'(e.err));
         end
      end else if (bus_err) begin
         check("bus_err_alone", 32'(bus_err), 32'h0);
      end
   end

   task automatic drop_req(input bit data);
      if (data) begin
         dm_read  = 1'b0;
         dm_write = 1'b0;
      end else begin
         if_req = 1'b0;
      end
   endtask

   task automatic drive(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
      if (kind == 0) begin
         if_req  = 1'b1;
         if_addr = addr;
      end else begin
         dm_read  = (kind != 2);
         dm_write = (kind >= 2);
         dm_addr  = addr;
         dm_wdata = wdata;
      end
   endtask

   // Waits (bounded) for the requester's ack; cyc counts cycles with the request cycle as 1
   task automatic wait_ack(input bit data, input bit drop_mid, input bit chk_stall,
                           input bit keep, output int cyc);
      bit held = 1'b1;
      bit ok   = 1'b0;
      cyc = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cyc++;
         if (data ? dm_ack : if_ack) begin
            if (chk_stall) check("stall_at_ack", 32'(stall), 32'h0);
            ok = 1'b1;
            break;
         end
         if (chk_stall) check("stall_wait", 32'(stall), 32'(held));
         if (drop_mid && held && mem_req) begin
            held = 1'b0;
            drop_req(data);
         end
      end
      if (!ok) check("ack_timeout", 32'(data ? dm_ack : if_ack), 32'h1);
      if (!keep) drop_req(data);
   endtask

   // kind: 0 fetch, 1 read, 2 write, 3 read+write
   task automatic single(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit drop, input int lat);
      acc_t a;
      ack_t k;
      int   cyc;
      int   eff;
      bit   we = (kind >= 2);
      a = '{we: we, addr: addr, wdata: wdata, lat: lat};
      k.is_data = (kind != 0);
      k.err     = (lat == NEVER);
      k.rdata   = (lat == NEVER || we) ? 32'h0 : ref_read(addr);
      if (we && lat != NEVER) ref_mem[addr] = wdata;
      exp_acc.push_back(a);
      exp_ack.push_back(k);
      @(negedge clk);
      check("stall_idle", 32'(stall), 32'h0);
      drive(kind, addr, wdata);
      wait_ack(kind != 0, drop, 1'b1, 1'b0, cyc);
      eff = (lat == NEVER) ? int'(TIMEOUT) : lat;
      check("latency", cyc, 3 + eff);
   endtask

   // One fetch contending with n_data back-to-back data accesses
   task automatic dual(input int n_data);
      int          kinds[];
      logic [31:0] addrs[];
      logic [31:0] wds[];
      logic [31:0] faddr;
      int          lead;
      kinds = new[n_data];
      addrs = new[n_data];
      wds   = new[n_data];
      faddr = 32'h0040_0100 + 32'($urandom_range(0, 15)) * 4;
      lead  = (n_data < int'(STARVE_LIMIT)) ? n_data : int'(STARVE_LIMIT);
      for (int i = 0; i < n_data; i++) begin
         kinds[i] = $urandom_range(1, 3);
         addrs[i] = 32'h1001_0000 + 32'($urandom_range(0, 7)) * 4;
         wds[i]   = $urandom;
      end
      for (int i = 0; i <= n_data; i++) begin
         acc_t a;
         ack_t k;
         int   lat = $urandom_range(0, 3);
         if (i == lead) begin
            a = '{we: 1'b0, addr: faddr, wdata: 32'h0, lat: lat};
            k = '{is_data: 1'b0, rdata: ref_read(faddr), err: 1'b0};
         end else begin
            int j = (i < lead) ? i : i - 1;
            bit we = (kinds[j] >= 2);
            a = '{we: we, addr: addrs[j], wdata: wds[j], lat: lat};
            k = '{is_data: 1'b1, rdata: we ? 32'h0 : ref_read(addrs[j]), err: 1'b0};
            if (we) ref_mem[addrs[j]] = wds[j];
         end
         exp_acc.push_back(a);
         exp_ack.push_back(k);
      end
      @(negedge clk);
      drive(0, faddr, 32'h0);
      drive(kinds[0], addrs[0], wds[0]);
      fork
         begin
            int c;
            wait_ack(1'b0, 1'b0, 1'b0, 1'b0, c);
         end
         begin
            for (int i = 0; i < n_data; i++) begin
               int c;
               if (i > 0) drive(kinds[i], addrs[i], wds[i]);
               wait_ack(1'b1, 1'b0, 1'b0, (i < n_data - 1), c);
            end
         end
      join
   endtask

   task automatic reset_mid_grant();
      bit seen = 1'b0;
      exp_acc.push_back('{we: 1'b0, addr: 32'h0040_0200, wdata: 32'h0, lat: NEVER});
      @(negedge clk);
      drive(0, 32'h0040_0200, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mem_req) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("rst_grant_seen", 32'(mem_req), 32'h1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_if_ack", 32'(if_ack), 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      if_req = 1'b0;
      rst_n  = 1'b1;
      repeat (TIMEOUT + 8) begin
         @(negedge clk);
         check("post_rst_idle", 32'(mem_req), 32'h0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_arr[32'h0040_0000] = 32'h8C88_0004;
      ref_mem[32'h0040_0000] = 32'h8C88_0004;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_if_ack", 32'(if_ack), 32'h0);
      check("rst_dm_ack", 32'(dm_ack), 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      rst_n = 1'b1;

      single(0, 32'h0040_0000, 32'h0, 1'b0, 0);
      single(2, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0, 0);
      single(1, 32'h1001_0000, 32'h0, 1'b0, 2);
      single(1, 32'h1001_0004, 32'h0, 1'b0, NEVER);
      single(0, 32'h0040_0004, 32'h0, 1'b0, int'(TIMEOUT));
      single(3, 32'h1001_0008, 32'h1234_5678, 1'b0, 1);
      single(0, 32'h0040_0008, 32'h0, 1'b1, 3);
      dual(1);
      dual(4);
      reset_mid_grant();
      single(0, 32'h0040_0000, 32'h0, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         int          kind = $urandom_range(0, 3);
         int          r    = $urandom_range(0, 9);
         int          lat  = (r == 0) ? NEVER : (r == 1) ? int'(TIMEOUT) : int'($urandom_range(0, 4));
         logic [31:0] addr = (kind == 0) ? 32'h0040_0000 + 32'($urandom_range(0, 15)) * 4
                                         : 32'h1001_0000 + 32'($urandom_range(0, 7)) * 4;
         single(kind, addr, $urandom, ($urandom_range(0, 3) == 0), lat);
      end
      dual(5);

      repeat (5) @(negedge clk);
      check("acc_queue_empty", exp_acc.size(), 32'h0);
      check("ack_queue_empty", exp_ack.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles a granted access waits for mem_ready before abort.
REQ-002 Parameter STARVE_LIMIT, default 2: max consecutive data grants while a fetch is pending.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched word; valid while if_ack=1.
REQ-009 dm_read  input  1  data-memory read request; held until dm_ack.
REQ-010 dm_write  input  1  data-memory write request; held until dm_ack.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  store data.
REQ-013 dm_ack  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data; valid while dm_ack=1.
REQ-015 mem_req  output  1  request to shared single-port memory.
REQ-016 mem_we  output  1  write enable to memory.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-020 mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-021 stall  output  1  pipeline stall request.
REQ-022 bus_err  output  1  one-cycle timeout pulse.

Function
REQ-023 FSM states SHALL be IDLE, GNT_DATA, GNT_FETCH.
REQ-024 mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata, bus_err SHALL be registered outputs.
REQ-025 IDLE arbitration: data pending (dm_read|dm_write) and starve count < STARVE_LIMIT -> GNT_DATA; else fetch pending -> GNT_FETCH; else stay IDLE.
REQ-026 A requester whose ack is high in the current cycle SHALL be ignored for arbitration that cycle.
REQ-027 On grant, next cycle mem_req=1 with mem_addr/mem_wdata/mem_we captured from the granted requester; values held constant through the grant.
REQ-028 dm_write=1 SHALL select mem_we=1 even if dm_read=1 simultaneously; fetch always mem_we=0.
REQ-029 In GNT_x, mem_ready=1 at a rising edge -> next cycle: mem_req=0, x_ack=1 for exactly one cycle, x_rdata=mem_rdata captured (0 for writes), state IDLE.
REQ-030 Minimum latency request->ack: 3 cycles with mem_ready asserted in the first grant cycle.
REQ-031 Wait counter (width ceil(log2(TIMEOUT+1))) SHALL clear on grant and increment each GNT_x cycle without mem_ready.
REQ-032 Counter reaching TIMEOUT without mem_ready -> next cycle: mem_req=0, x_ack=1, x_rdata=32'h0, bus_err=1 for one cycle, state IDLE.
REQ-033 mem_ready and counter==TIMEOUT in the same cycle SHALL complete normally, bus_err=0.
REQ-034 Starve counter SHALL increment on each data grant while if_req=1, clear on any fetch grant or when if_req=0, saturate at STARVE_LIMIT.
REQ-035 stall = (if_req & ~if_ack) | ((dm_read|dm_write) & ~dm_ack), combinational.
REQ-036 Requests deasserted mid-grant SHALL not abort the access; ack still issued.

Reset
REQ-037 rst_n=0 at a rising edge SHALL force state IDLE, all counters 0, all registered outputs 0, regardless of any access in flight.
REQ-038 A memory access interrupted by reset SHALL be abandoned; no ack or bus_err issued after reset release.
REQ-039 First arbitration SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x00400000, mem_ready=1 first grant cycle, mem_rdata=0x8C880004 -> mem_addr=0x00400000, if_ack pulse with if_rdata=0x8C880004, 3 cycles after request.
REQ-041 Simultaneous: if_req and dm_read both 1 in IDLE -> data granted first, fetch granted in IDLE cycle after dm_ack.
REQ-042 Starvation: if_req=1 held, dm_read re-asserted back-to-back -> exactly 2 data grants, then fetch grant.
REQ-043 Store: dm_write=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dm_ack with dm_rdata=0.
REQ-044 Timeout: mem_ready held 0 -> after 15 wait cycles, ack with rdata=0 and one-cycle bus_err; stall drops with ack.
REQ-045 Reset mid-grant: rst_n=0 during GNT_FETCH -> next cycle mem_req=0, if_ack=0; no ack after release until new request.
